top: RTL and testbench

//   Selectable power-of-two clock divider with output enable.

---
 rtl/top.sv | 55 +++++
 tb/tb_top.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Selectable power-of-two clock divider with a registered, glitch-free output.
// Ports: clk_i/rst_i (sync, active-high), oe_i enable, sel_i ratio select, dclk_o out.
module top #(
    parameter int CNT_W = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             oe_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             dclk_o
);

    localparam int KW = $clog2(CNT_W);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dclk_q;
    logic             dclk_d;

    logic [KW-1:0]    tap_k;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] mask;
    logic             rise;
    logic             tap_n;

    // sel_i is used combinationally, so a new select applies at the next edge.
    assign tap_k = KW'(CNT_W - 1) - KW'(sel_i);

    // half has only bit k set; mask covers bits k..0 (all ones when k is MSB).
    assign half = {{(CNT_W-1){1'b0}}, 1'b1} << tap_k;
    assign mask = (half << 1) - CNT_W'(1);

    assign cnt_d = cnt_q + CNT_W'(1);

    // A true rising edge of the tap is the single count where bits k..0 equal
    // 2^k; gating the set path on it prevents mid-phase (runt) rises.
    assign rise  = ((cnt_d & mask) == half);
    assign tap_n = |(cnt_d & half);

    assign dclk_d = oe_i & tap_n & (dclk_q | rise);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
        end
    end

    assign dclk_o = dclk_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the power-of-two clock divider.
// Directed sequences plus random stimulus against an arithmetic reference model.
module tb_top;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       oe_i;
    logic [2:0] sel_i;
    logic       dclk_o;

    top #(.CNT_W(16), .SEL_W(3)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .oe_i   (oe_i),
        .sel_i  (sel_i),
        .dclk_o (dclk_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mm     = 0;
    int mm_last = 0;

    // Reference model: counter value and expected output level.
    int m_cnt = 0;
    bit m_d   = 1'b0;

    // Output is high while the count's phase within one output period lies in
    // the upper half, but may only turn on exactly at the start of that half.
    function automatic bit model_next(int c, bit d, bit oe, int sel);
        int n;
        int hf;
        int ph;
        n  = (c + 1) % 65536;
        hf = 1 << (15 - sel);
        ph = n % (2 * hf);
        return oe && (ph >= hf) && (d || (ph == hf));
    endfunction

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_i) begin
            m_cnt <= 0;
            m_d   <= 1'b0;
        end else begin
            m_cnt <= (m_cnt + 1) % 65536;
            m_d   <= model_next(m_cnt, m_d, oe_i, int'(sel_i));
        end
    end

    always @(negedge clk_i) begin
        if (dclk_o !== m_d)
            mm <= mm + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ckpt(input string nm);
        int cur;
        @(posedge clk_i);
        #1;
        cur = mm;
        chk(nm, cur - mm_last, 0);
        mm_last = cur;
        @(negedge clk_i);
    endtask

    // Wait for a transition of dclk_o to lvl; returns cycle count at detection.
    task automatic wait_edge(input bit lvl, input int lim, output int at);
        bit last;
        bit seen;
        last = dclk_o;
        seen = 1'b0;
        at   = -1;
        for (int n = 0; n < lim && !seen; n++) begin
            @(negedge clk_i);
            if (dclk_o == lvl && last != lvl) begin
                seen = 1'b1;
                at   = cyc;
            end
            last = dclk_o;
        end
        if (!seen)
            chk("edge_timeout", int'(dclk_o), int'(lvl));
    endtask

    typedef struct {
        int sel;
        int per;
        int high;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int start;
        int r0;
        int r1;
        int r2;
        int f;
        int c0;
        int cyc0;
        int j;
        int highs;
        int rel;
        int budget;

        tbl[0] = '{sel: 5, per: 2048, high: 1024};
        tbl[1] = '{sel: 6, per: 1024, high: 512};
        tbl[2] = '{sel: 7, per: 512,  high: 256};

        // Reset, sel=0: first rise after 32768 edges.
        rst_i = 1'b1;
        oe_i  = 1'b1;
        sel_i = 3'd0;
        repeat (10) @(negedge clk_i);
        chk("reset_dclk", int'(dclk_o), 0);
        rst_i = 1'b0;
        start = cyc;
        rel   = cyc;
        wait_edge(1'b1, 40000, r1);
        chk("sel0_first_rise", r1 - start, 32768);

        // Table: change sel 2 cycles after a posedge, measure period and duty.
        foreach (tbl[i]) begin
            repeat (2) @(negedge clk_i);
            sel_i = tbl[i].sel[2:0];
            wait_edge(1'b1, 20000, r1);
            wait_edge(1'b0, 20000, f);
            wait_edge(1'b1, 20000, r2);
            chk($sformatf("tbl%0d_period", i), r2 - r1, tbl[i].per);
            chk($sformatf("tbl%0d_high", i), f - r1, tbl[i].high);
        end
        ckpt("model_tbl");

        // sel 7 -> 4 while output low and new tap already high.
        sel_i = 3'd7;
        budget = 0;
        @(negedge clk_i);
        while (!(m_cnt[11] == 1'b1 && m_cnt[8] == 1'b0 && dclk_o == 1'b0)
               && budget < 10000) begin
            @(negedge clk_i);
            budget++;
        end
        c0   = m_cnt;
        cyc0 = cyc;
        sel_i = 3'd4;
        wait_edge(1'b1, 10000, r1);
        chk("sel4_no_runt", r1 - cyc0, 6144 - (c0 % 4096));
        wait_edge(1'b1, 10000, r2);
        chk("sel4_period", r2 - r1, 4096);
        ckpt("model_sel4");

        // Output enable dropped mid-high for 1000 cycles.
        sel_i = 3'd7;
        wait_edge(1'b1, 5000, r1);
        repeat (100) @(negedge clk_i);
        oe_i = 1'b0;
        @(negedge clk_i);
        chk("oe_off_next", int'(dclk_o), 0);
        highs = 0;
        repeat (999) begin
            @(negedge clk_i);
            if (dclk_o) highs++;
        end
        chk("oe_off_low", highs, 0);
        c0   = m_cnt;
        cyc0 = cyc;
        oe_i = 1'b1;
        j = (256 - (c0 % 512) + 512) % 512;
        if (j == 0) j = 512;
        wait_edge(1'b1, 2000, r1);
        chk("oe_reen_rise", r1 - cyc0, j);
        wait_edge(1'b1, 2000, r2);
        chk("oe_reen_period", r2 - r1, 512);
        ckpt("model_oe");

        // sel=3 across the counter wrap.
        sel_i = 3'd3;
        wait_edge(1'b1, 20000, r0);
        for (int i = 0; i < 6; i++) begin
            wait_edge(1'b0, 20000, f);
            wait_edge(1'b1, 20000, r1);
            chk($sformatf("wrap%0d_high", i), f - r0, 4096);
            chk($sformatf("wrap%0d_period", i), r1 - r0, 8192);
            r0 = r1;
            if (cyc - rel > 65536 + 8192) break;
        end
        ckpt("model_wrap");

        // Reset while output high.
        sel_i = 3'd7;
        wait_edge(1'b1, 2000, r1);
        repeat (20) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_high", int'(dclk_o), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rel = cyc;
        wait_edge(1'b1, 2000, r1);
        chk("rst_first_rise", r1 - rel, 256);
        ckpt("model_rst");

        // Random select, enable and reset activity.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0)
                sel_i = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 149) == 0)
                oe_i = ~oe_i;
        end
        rst_i = 1'b0;
        ckpt("model_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
